// File: rtl/cic_pkg.sv
// Shared constants for the CIC decimator chain (integrators and combs) and a
// constant-evaluable clog2 helper used to size the decimation counter.
package cic_pkg;

  localparam int CIC_W = 10;  // data width, equal to the integrator chain width
  localparam int CIC_R = 8;   // decimation ratio
  localparam int CIC_M = 1;   // differential delay per comb stage
  localparam int CIC_N = 3;   // number of comb stages

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) stage: y = x[k] - x[k-M], modulo 2^W.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   sync_clr    synchronous clear of delay line, output and valid
//   x_vld, x    input sample strobe and sample
//   y_vld, y    registered output strobe (one cycle) and held output sample
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_W,
  parameter int M = CIC_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sync_clr,
  input  logic         x_vld,
  input  logic [W-1:0] x,
  output logic         y_vld,
  output logic [W-1:0] y
);

  // Delay line advances only on valid samples, so idle cycles never age it.
  logic [W-1:0] dly [M];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
      y     <= '0;
      y_vld <= 1'b0;
    end else if (sync_clr) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
      y     <= '0;
      y_vld <= 1'b0;
    end else begin
      y_vld <= x_vld;
      if (x_vld) begin
        // Plain wrap-around subtraction so integrator overflow cancels.
        y      <= x - dly[M-1];
        dly[0] <= x;
        for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_comb_decim.sv
// Decimating comb section of a CIC decimator: keeps one of every R valid
// input samples and runs it through N pipelined comb stages.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   din_vld     input sample strobe
//   din         integrator output sample (modular)
//   sync_clr    synchronous clear of all state, overrides a simultaneous capture
//   dout        comb output (two's-complement modular), held between strobes
//   dout_vld    single-cycle strobe, N cycles after the capture cycle
module cic_comb_decim
  import cic_pkg::*;
#(
  parameter int W = CIC_W,
  parameter int R = CIC_R,
  parameter int M = CIC_M,
  parameter int N = CIC_N
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         din_vld,
  input  logic [W-1:0] din,
  input  logic         sync_clr,
  output logic [W-1:0] dout,
  output logic         dout_vld
);

  // R=1 would give a zero-width counter; keep one bit, it simply stays at 0.
  localparam int CW = (R > 1) ? clog2(R) : 1;

  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          cap;

  assign cnt_last = (cnt == CW'(R - 1));
  assign cap      = din_vld & cnt_last & ~sync_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (din_vld) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

  // Index 0 is the captured sample; index N is the last stage output.
  logic [W-1:0] stg_d [N+1];
  logic         stg_v [N+1];

  assign stg_d[0] = din;
  assign stg_v[0] = cap;

  for (genvar g = 0; g < N; g++) begin : g_stage
    cic_comb_stage #(
      .W (W),
      .M (M)
    ) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .sync_clr (sync_clr),
      .x_vld    (stg_v[g]),
      .x        (stg_d[g]),
      .y_vld    (stg_v[g+1]),
      .y        (stg_d[g+1])
    );
  end

  assign dout     = stg_d[N];
  assign dout_vld = stg_v[N];

endmodule

// File: tb/tb_cic_comb_decim.sv
// Self-checking bench for cic_comb_decim. Four instances with different
// (R, M, N) share the same stimulus; a sequence-level model (N-fold M-lag
// differencing of the decimated sample history) predicts every output.
module tb_cic_comb_decim;

  localparam int ND = 4;
  localparam int PR [ND] = '{4, 1, 1, 8};
  localparam int PM [ND] = '{1, 1, 1, 2};
  localparam int PN [ND] = '{1, 3, 1, 3};

  logic       clk;
  logic       rstn;
  logic       din_vld;
  logic [9:0] din;
  logic       sync_clr;
  logic [9:0] dout_w   [ND];
  logic       dout_vld_w [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    cic_comb_decim #(
      .W (10),
      .R (PR[g]),
      .M (PM[g]),
      .N (PN[g])
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .din_vld  (din_vld),
      .din      (din),
      .sync_clr (sync_clr),
      .dout     (dout_w[g]),
      .dout_vld (dout_vld_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  int         m_cnt   [ND];
  int         hist    [ND][$];
  int         pend_v  [ND][$];
  int         pend_t  [ND][$];
  logic [9:0] exp_dout [ND];
  logic       exp_vld  [ND];

  // Output of N cascaded (1 - z^-M) filters on the captured history, newest sample.
  function automatic int comb_out(input int j);
    int d[$];
    int e[$];
    d = hist[j];
    for (int s = 0; s < PN[j]; s++) begin
      e.delete();
      for (int i = 0; i < d.size(); i++)
        e.push_back((d[i] - ((i >= PM[j]) ? d[i-PM[j]] : 0)) & 1023);
      d = e;
    end
    return d[d.size()-1];
  endfunction

  // Advance the model across one clock edge, then let the DUT take that edge.
  task automatic tick();
    cyc++;
    for (int j = 0; j < ND; j++) begin
      if (!rstn || sync_clr) begin
        m_cnt[j] = 0;
        hist[j].delete();
        pend_v[j].delete();
        pend_t[j].delete();
        exp_dout[j] = '0;
        exp_vld[j]  = 1'b0;
      end else begin
        if (din_vld) begin
          if (m_cnt[j] == PR[j] - 1) begin
            m_cnt[j] = 0;
            hist[j].push_back(int'(din));
            pend_v[j].push_back(comb_out(j));
            pend_t[j].push_back(cyc + PN[j] - 1);
          end else begin
            m_cnt[j]++;
          end
        end
        exp_vld[j] = 1'b0;
        if (pend_t[j].size() > 0 && pend_t[j][0] == cyc) begin
          exp_vld[j]  = 1'b1;
          exp_dout[j] = 10'(pend_v[j].pop_front());
          void'(pend_t[j].pop_front());
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_all();
    sync_clr = 1'b1; din_vld = 1'b0;
    tick();
    sync_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; din_vld = 1'b0; din = '0; sync_clr = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== 1'b0 || dout_w[j] !== 10'd0) begin
          n_err++;
          $display("FAIL reset_idle dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=0 dout=0",
                   j, cyc, dout_vld_w[j], dout_w[j]);
        end
      end
    end
  endtask

  task automatic test_decimation();
    int got_v[$];
    int got_t[$];
    int want_v[4] = '{3, 4, 4, 4};
    int want_t[4] = '{4, 8, 12, 16};
    clear_all();
    for (int i = 0; i < 18; i++) begin
      din_vld = (i < 16); din = 10'(i);
      tick();
      if (dout_vld_w[0]) begin got_v.push_back(int'(dout_w[0])); got_t.push_back(i + 1); end
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL decim_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    n_cmp++;
    if (got_v.size() !== 4) begin
      n_err++;
      $display("FAIL decim_count: got %0d strobes, want 4", got_v.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got_v[k] !== want_v[k] || got_t[k] !== want_t[k]) begin
          n_err++;
          $display("FAIL decim_seq[%0d]: got dout=%0d at tick %0d, want %0d at tick %0d",
                   k, got_v[k], got_t[k], want_v[k], want_t[k]);
        end
      end
    end
  endtask

  task automatic test_step();
    int got_v[$];
    int first_t;
    int want_v[4] = '{5, 1014, 5, 0};
    first_t = -1;
    clear_all();
    for (int i = 0; i < 10; i++) begin
      din_vld = 1'b1; din = 10'd5;
      tick();
      if (dout_vld_w[1]) begin
        got_v.push_back(int'(dout_w[1]));
        if (first_t < 0) first_t = i + 1;
      end
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL step_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    n_cmp++;
    if (first_t !== 3 || got_v.size() !== 8) begin
      n_err++;
      $display("FAIL step_timing: got first strobe tick %0d, %0d strobes; want tick 3, 8 strobes",
               first_t, got_v.size());
    end
    for (int k = 0; k < 4 && k < got_v.size(); k++) begin
      n_cmp++;
      if (got_v[k] !== want_v[k]) begin
        n_err++;
        $display("FAIL step_seq[%0d]: got %0d, want %0d", k, got_v[k], want_v[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int got_v[$];
    clear_all();
    for (int i = 0; i < 4; i++) begin
      din_vld = (i < 2); din = (i == 0) ? 10'd1020 : 10'd4;
      tick();
      if (dout_vld_w[2]) got_v.push_back(int'(dout_w[2]));
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL wrap_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    n_cmp++;
    if (got_v.size() !== 2 || got_v[0] !== 1020 || got_v[1] !== 8) begin
      n_err++;
      $display("FAIL wrap_seq: got %0d strobes (%p), want 1020 then 8", got_v.size(), got_v);
    end
  endtask

  task automatic test_gapped();
    int n_vld;
    n_vld = 0;
    clear_all();
    for (int i = 0; i < 64; i++) begin
      din_vld = (i % 2 == 0); din = 10'($urandom);
      tick();
      if (dout_vld_w[0]) n_vld++;
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL gapped_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    n_cmp++;
    if (n_vld !== 8) begin
      n_err++;
      $display("FAIL gapped_count: got %0d strobes, want 8", n_vld);
    end
  endtask

  // use_rst=0: sync_clr after the capture; use_rst=1: rstn pulse instead.
  task automatic test_clear(input bit use_rst);
    int n_vld;
    int first_v;
    int first_t;
    n_vld = 0; first_v = -1; first_t = -1;
    clear_all();
    din_vld = 1'b1; din = 10'd300;
    tick();
    din_vld = 1'b1; din = 10'd200;
    if (use_rst) rstn = 1'b0; else sync_clr = 1'b1;
    tick();
    rstn = 1'b1; sync_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      din_vld = (i == 6); din = (i == 6) ? 10'd77 : 10'($urandom);
      tick();
      if (i < 6 && dout_vld_w[1]) n_vld++;
      if (i == 5) begin
        n_cmp++;
        if (dout_w[1] !== 10'd0) begin
          n_err++;
          $display("FAIL clear_dout rst=%0b: got %0d, want 0", use_rst, dout_w[1]);
        end
      end
      if (i >= 6 && dout_vld_w[1] && first_t < 0) begin first_v = int'(dout_w[1]); first_t = i - 5; end
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL clear_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    n_cmp++;
    if (n_vld !== 0) begin
      n_err++;
      $display("FAIL clear_cancel rst=%0b: got %0d stale strobes, want 0", use_rst, n_vld);
    end
    n_cmp++;
    if (first_v !== 77 || first_t !== 3) begin
      n_err++;
      $display("FAIL clear_first rst=%0b: got dout=%0d at tick %0d, want 77 at tick 3",
               use_rst, first_v, first_t);
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int i = 0; i < 500; i++) begin
      din_vld  = ($urandom_range(0, 3) != 0);
      din      = 10'($urandom);
      sync_clr = ($urandom_range(0, 59) == 0);
      tick();
      for (int j = 0; j < ND; j++) begin
        n_cmp++;
        if (dout_vld_w[j] !== exp_vld[j] || dout_w[j] !== exp_dout[j]) begin
          n_err++;
          $display("FAIL random_model dut%0d cyc%0d: got vld=%0b dout=%0d, want vld=%0b dout=%0d",
                   j, cyc, dout_vld_w[j], dout_w[j], exp_vld[j], exp_dout[j]);
        end
      end
    end
    sync_clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; din_vld = 1'b0; din = '0; sync_clr = 1'b0;
    for (int j = 0; j < ND; j++) begin
      m_cnt[j] = 0; exp_dout[j] = '0; exp_vld[j] = 1'b0;
    end
    test_reset();
    test_decimation();
    test_step();
    test_wrap();
    test_gapped();
    test_clear(1'b0);
    test_clear(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cic_comb_decim.md
Name: cic_comb_decim

Overview:
Decimating comb section of a CIC decimator. It sits downstream of the cascaded integrator stages.
- Keeps one of every R valid input samples.
- Passes each kept sample through N pipelined comb (differentiator) stages, y = x[k] - x[k-M].
- Emits the filtered sample with a one-cycle valid strobe.

Parameters:
W, 10, data width; must equal the width of the feeding integrator chain
R, 8, decimation ratio (>=1)
M, 1, differential delay per comb stage (1 or 2)
N, 3, number of comb stages (>=1)

Ports:
clk  input  1  clock
rstn  input  1  reset
din_vld  input  1  input sample strobe; din is valid when high
din  input  W  integrator output sample, unsigned/two's-complement modular
sync_clr  input  1  synchronous clear of all state
dout  output  W  comb output, two's-complement modular
dout_vld  output  1  single-cycle strobe, dout valid

Interface (already decided): reset rstn, asynchronous, active-low; clock clk.

Behaviour:
- Reset (rstn=0) clears everything immediately:
  - decimation counter, all delay lines and pipeline registers -> 0
  - dout=0, dout_vld=0
- Decimation counter:
  - width clog2(R), range 0..R-1.
  - Increments only on din_vld=1; wraps R-1 -> 0.
  - Capture event: din_vld=1 and cnt==R-1. That din becomes decimated sample x[k].
  - R=1: every valid input is captured.
  - Cycles with din_vld=0 change nothing.
- Comb stage i (1..N):
  - Holds an M-deep delay line of its own input samples.
  - On a valid input x: registers y = x - delay[M-1] mod 2^W, shifts x into the delay line, and asserts its valid output next cycle.
  - Delay lines shift only on valid samples, never on idle cycles.
- Latency:
  - Capture in cycle t -> stage 1 output registered at t+1 -> stage N output at t+N.
  - dout_vld=1 for exactly cycle t+N per captured sample.
  - Back-to-back captures (R=1) give back-to-back dout_vld; the pipeline never stalls.
- dout holds its last value between strobes.
- Arithmetic: pure W-bit wrap-around subtraction; no saturation, no growth. This is required so the modular integrator overflow cancels.
- Start-up: the first M samples at each stage subtract zeros from the reset delay lines. This transient is expected, not flagged.
- sync_clr=1 (synchronous):
  - Same clear as reset at the next edge, including cancellation of in-flight valids.
  - Has priority over a simultaneous capture; that din is discarded.
- Reset or sync_clr mid-operation: no dout_vld may appear afterwards for samples captured before the clear.

Decomposition:
- Shared package cic_pkg holds:
  - default W, R, M, N constants shared with the integrator chain
  - a clog2 function for the counter width
- One sub-module, cic_comb_stage (params W, M): valid-gated M-deep delay line, subtractor, output register, valid register, sync_clr input.
- Top level contains the decimation counter, capture logic and a generate loop of N stages.

Test Plan:
1. Reset/idle: rstn low then high, din_vld=0 for 20 cycles -> dout=0, dout_vld=0 throughout.
2. Decimation and latency (N=1, M=1, R=4): din_vld=1 continuously, din=0,1,2,...
   - Captures 3,7,11,15.
   - dout = 3,4,4,4, each 1 cycle after its capture cycle.
3. Step response (N=3, M=1, R=1): din=5 every cycle -> dout sequence 5, 1014, 5, 0, 0..., first strobe 3 cycles after the first capture.
4. Wrap-around (N=1, M=1, R=1, W=10): din 1020 then 4 -> dout 1020 then 8.
5. Gapped input (R=4): din_vld toggles 1,0,1,0... -> a capture every 8 cycles; din values on din_vld=0 cycles are never used.
6. Clear mid-flight (N=3): assert sync_clr 1 cycle after a capture -> no dout_vld for that sample, dout=0, next capture behaves as a post-reset first sample. Repeat the same sequence using a rstn pulse -> identical outcome.
